// File: rtl/vec_mag_pkg.sv
// rtl/vec_mag_pkg.sv - shared state type and width helpers for vec_mag_seq
// Widths are derived from the operand width W so every file agrees on them.
package vec_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROOT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int out_w_f(input int w);
    return w + 1;
  endfunction

  function automatic int sum_w_f(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int rem_w_f(input int w);
    return w + 2;
  endfunction

  // One spare bit over the final remainder covers the pre-subtract partial value.
  function automatic int acc_w_f(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/vec_mag_seq_if.sv
// rtl/vec_mag_seq_if.sv - operand/result handshake bundle for vec_mag_seq
// The slave modport is the unit side; master is the producer/consumer side.
interface vec_mag_seq_if #(
  parameter int W = 8
);
  import vec_mag_pkg::*;

  localparam int OUT_W = out_w_f(W);
  localparam int REM_W = rem_w_f(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x_in;
  logic [W-1:0]     y_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] root_out;
  logic [REM_W-1:0] rem_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, root_out, rem_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, root_out, rem_out
  );

endinterface

// File: rtl/vec_mag_seq_isqrt_step.sv
// rtl/vec_mag_seq_isqrt_step.sv - one combinational digit-by-digit square-root iteration
// Consumes one base-4 digit of the radicand and yields one root bit.
module isqrt_step #(
  parameter int W = 8
) (
  input  logic [W+2:0] rem_i,
  input  logic [W:0]   root_i,
  input  logic [1:0]   digit_i,
  output logic [W+2:0] rem_next_o,
  output logic [W:0]   root_next_o
);

  localparam int EXT_W = W + 5;

  logic [EXT_W-1:0] rem_sh;
  logic [EXT_W-1:0] trial;
  logic [EXT_W-1:0] diff;
  logic             take;

  assign rem_sh = {rem_i, digit_i};
  assign trial  = {2'b00, root_i, 2'b01};
  assign diff   = rem_sh - trial;
  assign take   = (rem_sh >= trial);

  // The kept remainder is bounded by twice the new root, so it always fits W+3 bits.
  assign rem_next_o  = (W + 3)'(take ? diff : rem_sh);
  assign root_next_o = (root_i << 1) | {{W{1'b0}}, take};

endmodule

// File: rtl/vec_mag_seq.sv
// rtl/vec_mag_seq.sv - sequential floor(sqrt(x^2+y^2)) with remainder, one root bit per cycle
// Optional VEC_MAG_ROUND_EN rounds the reported root half-up to nearest.
module vec_mag_seq
  import vec_mag_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  vec_mag_seq_if.slave bus,
  output logic         busy
);

  localparam int OUT_W = out_w_f(W);
  localparam int SUM_W = sum_w_f(W);
  localparam int REM_W = rem_w_f(W);
  localparam int ACC_W = acc_w_f(W);
  localparam int K_W   = $clog2(OUT_W);

  state_e           state_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic [ACC_W-1:0] rem_q;
  logic [ACC_W-1:0] rem_d;
  logic [OUT_W-1:0] root_q;
  logic [OUT_W-1:0] root_d;
  logic [K_W-1:0]   k_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] root_out_q;
  logic [OUT_W-1:0] root_res;
  logic [REM_W-1:0] rem_out_q;
  logic [1:0]       digit;

  assign sum_d = SUM_W'(bus.x_in) * SUM_W'(bus.x_in)
               + SUM_W'(bus.y_in) * SUM_W'(bus.y_in);

  // Radicand digits are consumed MSB pair first as k counts down.
  assign digit = 2'(sum_q >> {k_q, 1'b0});

  isqrt_step #(.W(W)) u_step (
    .rem_i       (rem_q),
    .root_i      (root_q),
    .digit_i     (digit),
    .rem_next_o  (rem_d),
    .root_next_o (root_d)
  );

`ifdef VEC_MAG_ROUND_EN
  assign root_res = (rem_q > ACC_W'(root_q)) ? root_q + OUT_W'(1) : root_q;
`else
  assign root_res = root_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      root_out_q  <= '0;
      rem_out_q   <= '0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sum_q   <= sum_d;
            rem_q   <= '0;
            root_q  <= '0;
            k_q     <= K_W'(OUT_W - 1);
            state_q <= ROOT;
          end
        end
        ROOT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          if (k_q == '0) begin
            state_q <= DONE;
          end else begin
            k_q <= k_q - K_W'(1);
          end
        end
        DONE: begin
          // First DONE cycle latches the result; later cycles wait for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            root_out_q  <= root_res;
            rem_out_q   <= REM_W'(rem_q);
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n & ena & (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.root_out  = root_out_q;
  assign bus.rem_out   = rem_out_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vec_mag_seq.sv
// tb/tb_vec_mag_seq.sv - scoreboard bench for vec_mag_seq with an arithmetic reference model
// Directed boundary cases followed by randomized operands under random backpressure.
module tb_vec_mag_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic busy;

  vec_mag_seq_if #(.W(W)) bus ();

  vec_mag_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_root_q[$];
  int exp_rem_q[$];
  bit rand_bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: exhaustive integer search for the floor root, then optional rounding.
  function automatic void model(input int x, input int y, output int r, output int m);
    int s;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    m = s - r * r;
`ifdef VEC_MAG_ROUND_EN
    if (m > r) r = r + 1;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int x, input int y);
    int rr;
    int mm;
    bit ok;
    ok = 1'b0;
    bus.x_in = W'(x);
    bus.y_in = W'(y);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        model(x, y, rr, mm);
        exp_root_q.push_back(rr);
        exp_rem_q.push_back(mm);
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 32'(ok), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges since the accept edge until out_valid is seen.
  task automatic wait_valid(input bit stall, output int lat);
    int c;
    c = 0;
    lat = -1;
    while (c < 100) begin
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      tick();
      c++;
      if (stall) ena = !(c >= 3 && c < 6);
    end
    ena = 1'b1;
    if (lat < 0) chk("valid_timeout", 32'(lat), 0);
  endtask

  task automatic directed(input int x, input int y, input int er, input int em, input string tag);
    int lat;
    send(x, y);
    wait_valid(1'b0, lat);
    chk({tag, "_latency"}, 32'(lat), 10);
    chk({tag, "_root"}, 32'(bus.root_out), er);
    chk({tag, "_rem"}, 32'(bus.rem_out), em);
    tick();
    #1;
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 1);
  endtask

  initial begin : monitor
    int r;
    int m;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ena && bus.out_valid && bus.out_ready) begin
        if (exp_root_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 0);
        end else begin
          r = exp_root_q.pop_front();
          m = exp_rem_q.pop_front();
          chk("mon_root", 32'(bus.root_out), r);
          chk("mon_rem", 32'(bus.rem_out), m);
        end
      end
    end
  end

  initial begin : stim
    int lat;
    int r0;
    int m0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.out_ready = 1'b0;
    ena = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_root", 32'(bus.root_out), 0);
    chk("rst_rem", 32'(bus.rem_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;

    directed(3, 4, 5, 0, "basic");
`ifdef VEC_MAG_ROUND_EN
    directed(255, 255, 361, 450, "max");
    directed(2, 2, 3, 4, "two");
`else
    directed(255, 255, 360, 450, "max");
    directed(2, 2, 2, 4, "two");
`endif
    directed(0, 0, 0, 0, "zero");
    directed(1, 1, 1, 1, "one");

    // Backpressure with an in_valid pulse that must be ignored.
    bus.out_ready = 1'b0;
    send(7, 24);
    wait_valid(1'b0, lat);
    chk("bp_root", 32'(bus.root_out), 25);
    r0 = int'(bus.root_out);
    m0 = int'(bus.rem_out);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) begin
        bus.x_in = W'(1);
        bus.y_in = W'(1);
        bus.in_valid = 1'b1;
      end
      if (i == 3) bus.in_valid = 1'b0;
      #1;
      chk("bp_valid_hold", 32'(bus.out_valid), 1);
      chk("bp_root_hold", 32'(bus.root_out), r0);
      chk("bp_rem_hold", 32'(bus.rem_out), m0);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    #1;
    chk("bp_busy_after", 32'(busy), 0);
    directed(8, 15, 17, 0, "after_bp");

    // ena dropped for three cycles while iterating.
    send(12, 5);
    wait_valid(1'b1, lat);
    chk("stall_latency", 32'(lat), 13);
    chk("stall_root", 32'(bus.root_out), 13);
    chk("stall_rem", 32'(bus.rem_out), 0);
    tick();

    // Reset in the middle of ROOT discards the operation.
    send(9, 9);
    repeat (4) tick();
    rst_n = 1'b0;
    exp_root_q.delete();
    exp_rem_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_root", 32'(bus.root_out), 0);
    chk("abort_rem", 32'(bus.rem_out), 0);
    repeat (20) tick();
    chk("abort_no_result", 32'(bus.out_valid), 0);
    directed(6, 8, 10, 0, "post_reset");

    // Randomized operands under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 400 && exp_root_q.size() != 0; i++) tick();
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("drain_empty", 32'(exp_root_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
